// File: rtl/z80fi_insn_recorder_pkg.sv
// Shared constants and types for the z80fi retirement record producer.
// Field widths, register-number encoding and the recorder state type.
package z80fi_insn_recorder_pkg;

    localparam int MAX_LEN_DEF = 4;
    localparam int BYTE_W      = 8;
    localparam int PC_W        = 16;
    localparam int LEN_W       = 3;
    localparam int REG_NUM_W   = 4;
    localparam int REG_DATA_W  = 16;

    // 8-bit registers use the Z80 r-field numbering; pairs are {2'b10, dd}.
    localparam logic [REG_NUM_W-1:0] REG_B  = 4'b0000;
    localparam logic [REG_NUM_W-1:0] REG_C  = 4'b0001;
    localparam logic [REG_NUM_W-1:0] REG_D  = 4'b0010;
    localparam logic [REG_NUM_W-1:0] REG_E  = 4'b0011;
    localparam logic [REG_NUM_W-1:0] REG_H  = 4'b0100;
    localparam logic [REG_NUM_W-1:0] REG_L  = 4'b0101;
    localparam logic [REG_NUM_W-1:0] REG_A  = 4'b0111;
    localparam logic [1:0]           REG_PAIR_PFX = 2'b10;
    localparam logic [REG_NUM_W-1:0] REG_BC = {REG_PAIR_PFX, 2'b00};
    localparam logic [REG_NUM_W-1:0] REG_DE = {REG_PAIR_PFX, 2'b01};
    localparam logic [REG_NUM_W-1:0] REG_HL = {REG_PAIR_PFX, 2'b10};
    localparam logic [REG_NUM_W-1:0] REG_SP = {REG_PAIR_PFX, 2'b11};

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } rec_state_e;

    function automatic logic is_reg_pair(input logic [REG_NUM_W-1:0] num);
        return num[3:2] == REG_PAIR_PFX;
    endfunction

endpackage

// File: rtl/z80fi_insn_recorder_if.sv
// Core-side observation signals and the retirement record they produce.
// Core signals are sampled on clk; the record fields hold until the next z80fi_valid.
interface z80fi_insn_recorder_if #(
    parameter int MAX_LEN = z80fi_insn_recorder_pkg::MAX_LEN_DEF
);
    import z80fi_insn_recorder_pkg::*;

    logic                    insn_start;
    logic [PC_W-1:0]         insn_pc;
    logic                    fetch_valid;
    logic [BYTE_W-1:0]       fetch_data;
    logic                    wb_valid;
    logic [REG_NUM_W-1:0]    wb_num;
    logic [REG_DATA_W-1:0]   wb_data;
    logic                    retire;

    logic                    z80fi_valid;
    logic [8*MAX_LEN-1:0]    z80fi_insn;
    logic [LEN_W-1:0]        z80fi_insn_len;
    logic [PC_W-1:0]         z80fi_pc_rdata;
    logic                    z80fi_reg_wr;
    logic [REG_NUM_W-1:0]    z80fi_reg_wnum;
    logic [REG_DATA_W-1:0]   z80fi_reg_wdata;
    logic                    rec_overflow;
    logic                    rec_error;
    rec_state_e              dbg_state;

    modport master (
        output insn_start, insn_pc, fetch_valid, fetch_data,
               wb_valid, wb_num, wb_data, retire,
        input  z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_pc_rdata,
               z80fi_reg_wr, z80fi_reg_wnum, z80fi_reg_wdata,
               rec_overflow, rec_error, dbg_state
    );

    modport slave (
        input  insn_start, insn_pc, fetch_valid, fetch_data,
               wb_valid, wb_num, wb_data, retire,
        output z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_pc_rdata,
               z80fi_reg_wr, z80fi_reg_wnum, z80fi_reg_wdata,
               rec_overflow, rec_error, dbg_state
    );

endinterface

// File: rtl/z80fi_insn_recorder_byte_collector.sv
// Instruction byte buffer with saturating count and overflow flag.
// cur_* show the buffer including this cycle's byte, before any clear takes effect.
module z80fi_insn_recorder_byte_collector
    import z80fi_insn_recorder_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            clear_i,
    input  logic                            push_i,
    input  logic                            in_retire_i,
    input  logic [BYTE_W-1:0]               data_i,
    output logic [MAX_LEN-1:0][BYTE_W-1:0]  cur_bytes_o,
    output logic [LEN_W-1:0]                cur_count_o,
    output logic                            cur_ovf_o
);

    logic [MAX_LEN-1:0][BYTE_W-1:0] bytes_q, bytes_d;
    logic [LEN_W-1:0]               count_q, count_d;
    logic                           ovf_q, ovf_d;
    logic                           push_old;
    logic                           push_new;

    // In a retire cycle the byte belongs to the retiring instruction, otherwise
    // a clear means it is byte 0 of the new one.
    assign push_old = push_i && (!clear_i || in_retire_i);
    assign push_new = push_i && clear_i && !in_retire_i;

    always_comb begin
        cur_bytes_o = bytes_q;
        cur_count_o = count_q;
        cur_ovf_o   = ovf_q;
        if (push_old) begin
            if (count_q == LEN_W'(MAX_LEN)) begin
                cur_ovf_o = 1'b1;
            end else begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (count_q == LEN_W'(i)) begin
                        cur_bytes_o[i] = data_i;
                    end
                end
                cur_count_o = count_q + LEN_W'(1);
            end
        end

        bytes_d = cur_bytes_o;
        count_d = cur_count_o;
        ovf_d   = cur_ovf_o;
        if (clear_i) begin
            bytes_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            if (push_new) begin
                bytes_d[0] = data_i;
                count_d    = LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bytes_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            bytes_q <= bytes_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: rtl/z80fi_insn_recorder.sv
// Assembles one z80fi retirement record per instruction from core boundary,
// fetch and writeback events, and strobes it out one cycle after retire.
module z80fi_insn_recorder
    import z80fi_insn_recorder_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    z80fi_insn_recorder_if.slave bus
);

    rec_state_e                     state_q, state_d;
    logic [PC_W-1:0]                pc_q, pc_d;
    logic                           wr_pend_q, wr_pend_d;
    logic [REG_NUM_W-1:0]           wnum_q, wnum_d;
    logic [REG_DATA_W-1:0]          wdata_q, wdata_d;
    logic                           err_q, err_d;

    logic                           out_valid_q, out_valid_d;
    logic [MAX_LEN-1:0][BYTE_W-1:0] out_insn_q, out_insn_d;
    logic [LEN_W-1:0]               out_len_q, out_len_d;
    logic [PC_W-1:0]                out_pc_q, out_pc_d;
    logic                           out_wr_q, out_wr_d;
    logic [REG_NUM_W-1:0]           out_wnum_q, out_wnum_d;
    logic [REG_DATA_W-1:0]          out_wdata_q, out_wdata_d;
    logic                           out_ovf_q, out_ovf_d;

    logic                           in_collect;
    logic                           do_retire;
    logic                           push;
    logic [MAX_LEN-1:0][BYTE_W-1:0] cur_bytes;
    logic [LEN_W-1:0]               cur_count;
    logic                           cur_ovf;

    assign in_collect = (state_q == ST_COLLECT);
    assign do_retire  = bus.retire && in_collect;
    assign push       = bus.fetch_valid && (in_collect || bus.insn_start);

    z80fi_insn_recorder_byte_collector #(.MAX_LEN(MAX_LEN)) u_bytes (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (bus.insn_start),
        .push_i      (push),
        .in_retire_i (do_retire),
        .data_i      (bus.fetch_data),
        .cur_bytes_o (cur_bytes),
        .cur_count_o (cur_count),
        .cur_ovf_o   (cur_ovf)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        wr_pend_d   = wr_pend_q;
        wnum_d      = wnum_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        out_valid_d = 1'b0;
        out_insn_d  = out_insn_q;
        out_len_d   = out_len_q;
        out_pc_d    = out_pc_q;
        out_wr_d    = out_wr_q;
        out_wnum_d  = out_wnum_q;
        out_wdata_d = out_wdata_q;
        out_ovf_d   = out_ovf_q;

        if (bus.wb_valid && in_collect) begin
            wr_pend_d = 1'b1;
            wnum_d    = bus.wb_num;
            wdata_d   = bus.wb_data;
        end

        // The record sees the writeback state including this cycle's wb.
        if (do_retire) begin
            if (cur_count != '0) begin
                out_valid_d = 1'b1;
                out_insn_d  = cur_bytes;
                out_len_d   = cur_count;
                out_pc_d    = pc_q;
                out_ovf_d   = cur_ovf;
                out_wr_d    = wr_pend_d;
                out_wnum_d  = wr_pend_d ? wnum_d  : '0;
                out_wdata_d = wr_pend_d ? wdata_d : '0;
            end else begin
                err_d = 1'b1;
            end
        end

        if (bus.insn_start) begin
            state_d   = ST_COLLECT;
            pc_d      = bus.insn_pc;
            wr_pend_d = 1'b0;
        end else if (do_retire) begin
            state_d   = ST_IDLE;
        end

        if (bus.retire && !in_collect)                        err_d = 1'b1;
        if (bus.insn_start && in_collect && !bus.retire)      err_d = 1'b1;
        if (bus.fetch_valid && !in_collect && !bus.insn_start) err_d = 1'b1;
        if (bus.wb_valid && !in_collect)                      err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            wr_pend_q   <= 1'b0;
            wnum_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_insn_q  <= '0;
            out_len_q   <= '0;
            out_pc_q    <= '0;
            out_wr_q    <= 1'b0;
            out_wnum_q  <= '0;
            out_wdata_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wr_pend_q   <= wr_pend_d;
            wnum_q      <= wnum_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_insn_q  <= out_insn_d;
            out_len_q   <= out_len_d;
            out_pc_q    <= out_pc_d;
            out_wr_q    <= out_wr_d;
            out_wnum_q  <= out_wnum_d;
            out_wdata_q <= out_wdata_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.z80fi_valid     = out_valid_q;
    assign bus.z80fi_insn      = out_insn_q;
    assign bus.z80fi_insn_len  = out_len_q;
    assign bus.z80fi_pc_rdata  = out_pc_q;
    assign bus.z80fi_reg_wr    = out_wr_q;
    assign bus.z80fi_reg_wnum  = out_wnum_q;
    assign bus.z80fi_reg_wdata = out_wdata_q;
    assign bus.rec_overflow    = out_ovf_q;
    assign bus.rec_error       = err_q;
    assign bus.dbg_state       = state_q;

endmodule

// File: tb/tb_z80fi_insn_recorder.sv
// Directed-vector bench for z80fi_insn_recorder: record contents, back-to-back
// retire, overflow, protocol errors and asynchronous reset.
module tb_z80fi_insn_recorder;
  import z80fi_insn_recorder_pkg::*;

  logic clk;
  logic reset_n;
  int n_vec;
  int n_bad;
  logic [15:0] exp_q[$];

  z80fi_insn_recorder_if #(.MAX_LEN(4)) bus ();

  z80fi_insn_recorder #(.MAX_LEN(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every valid pulse must match the next expected PC
  always @(negedge clk) begin
    if (bus.z80fi_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
      else chk("valid_pc", bus.z80fi_pc_rdata, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic clear_inputs();
    bus.insn_start  = 1'b0;
    bus.insn_pc     = 16'h0;
    bus.fetch_valid = 1'b0;
    bus.fetch_data  = 8'h0;
    bus.wb_valid    = 1'b0;
    bus.wb_num      = 4'h0;
    bus.wb_data     = 16'h0;
    bus.retire      = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic start(input logic [15:0] pc);
    bus.insn_start = 1'b1;
    bus.insn_pc    = pc;
  endtask

  task automatic fetch(input logic [7:0] b);
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = b;
  endtask

  task automatic wb(input logic [3:0] num, input logic [15:0] data);
    bus.wb_valid = 1'b1;
    bus.wb_num   = num;
    bus.wb_data  = data;
  endtask

  task automatic check_rec(input string tag, input logic [31:0] insn, input logic [2:0] len,
                           input logic [15:0] pc, input logic wr, input logic [3:0] wnum,
                           input logic [15:0] wdata, input logic ovf);
    chk({tag, "_valid"}, bus.z80fi_valid, 1'b1);
    chk({tag, "_insn"},  bus.z80fi_insn, insn);
    chk({tag, "_len"},   bus.z80fi_insn_len, len);
    chk({tag, "_pc"},    bus.z80fi_pc_rdata, pc);
    chk({tag, "_wr"},    bus.z80fi_reg_wr, wr);
    chk({tag, "_wnum"},  bus.z80fi_reg_wnum, wnum);
    chk({tag, "_wdata"}, bus.z80fi_reg_wdata, wdata);
    chk({tag, "_ovf"},   bus.rec_overflow, ovf);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, bus.z80fi_valid, 0);
    chk({tag, "_insn"},  bus.z80fi_insn, 0);
    chk({tag, "_len"},   bus.z80fi_insn_len, 0);
    chk({tag, "_pc"},    bus.z80fi_pc_rdata, 0);
    chk({tag, "_wr"},    bus.z80fi_reg_wr, 0);
    chk({tag, "_wnum"},  bus.z80fi_reg_wnum, 0);
    chk({tag, "_wdata"}, bus.z80fi_reg_wdata, 0);
    chk({tag, "_ovf"},   bus.rec_overflow, 0);
    chk({tag, "_err"},   bus.rec_error, 0);
    chk({tag, "_state"}, bus.dbg_state, ST_IDLE);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // LD BC,1234h
    start(16'h0100); fetch(8'h01); step();
    chk("ldbc_state", bus.dbg_state, ST_COLLECT);
    fetch(8'h34); step();
    fetch(8'h12); wb(REG_BC, 16'h1234); step();
    bus.retire = 1'b1; exp_q.push_back(16'h0100); step();
    check_rec("ldbc", 32'h00123401, 3'd3, 16'h0100, 1'b1, 4'h8, 16'h1234, 1'b0);
    chk("ldbc_err", bus.rec_error, 0);
    step();
    chk("ldbc_pulse_end", bus.z80fi_valid, 0);
    chk("ldbc_hold_insn", bus.z80fi_insn, 32'h00123401);
    chk("ldbc_idle", bus.dbg_state, ST_IDLE);

    // back-to-back: LD SP,8000h retires as NOP at 0103h starts
    start(16'h0100); fetch(8'h31); step();
    fetch(8'h00); step();
    fetch(8'h80); wb(REG_SP, 16'h8000); step();
    bus.retire = 1'b1; start(16'h0103); exp_q.push_back(16'h0100); step();
    check_rec("ldsp", 32'h00800031, 3'd3, 16'h0100, 1'b1, 4'hB, 16'h8000, 1'b0);
    chk("ldsp_state", bus.dbg_state, ST_COLLECT);
    fetch(8'h00); bus.retire = 1'b1; exp_q.push_back(16'h0103); step();
    check_rec("nop", 32'h00000000, 3'd1, 16'h0103, 1'b0, 4'h0, 16'h0, 1'b0);
    step();

    // overflow: five bytes into a four-byte record
    start(16'h0200); fetch(8'hDD); step();
    fetch(8'hCB); step();
    fetch(8'h05); step();
    fetch(8'h06); step();
    fetch(8'hAA); step();
    bus.retire = 1'b1; exp_q.push_back(16'h0200); step();
    check_rec("ovf", 32'h0605CBDD, 3'd4, 16'h0200, 1'b0, 4'h0, 16'h0, 1'b1);
    chk("ovf_err", bus.rec_error, 0);
    step();

    // final byte and writeback in the retire cycle
    start(16'h0300); fetch(8'h21); step();
    fetch(8'h34); step();
    fetch(8'h56); wb(REG_HL, 16'h5634); bus.retire = 1'b1; exp_q.push_back(16'h0300); step();
    check_rec("late", 32'h00563421, 3'd3, 16'h0300, 1'b1, 4'hA, 16'h5634, 1'b0);
    chk("late_err", bus.rec_error, 0);
    step();

    // protocol errors
    bus.retire = 1'b1; step();
    chk("idle_retire_valid", bus.z80fi_valid, 0);
    chk("idle_retire_err", bus.rec_error, 1);
    start(16'h0500); fetch(8'h00); step();
    start(16'h0600); fetch(8'h3C); step();
    bus.retire = 1'b1; exp_q.push_back(16'h0600); step();
    check_rec("restart", 32'h0000003C, 3'd1, 16'h0600, 1'b0, 4'h0, 16'h0, 1'b0);
    chk("restart_err", bus.rec_error, 1);
    step();

    // asynchronous reset mid-instruction
    start(16'h0700); fetch(8'h01); step();
    fetch(8'h02); step();
    #1 reset_n = 1'b0;
    #1 check_all_zero("areset");
    #2 reset_n = 1'b1;
    step();
    bus.retire = 1'b1; step();
    chk("areset_no_valid", bus.z80fi_valid, 0);
    chk("areset_retire_err", bus.rec_error, 1);

    // retire of an instruction with no bytes is suppressed
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    step();
    start(16'h0800); step();
    bus.retire = 1'b1; step();
    chk("empty_valid", bus.z80fi_valid, 0);
    chk("empty_err", bus.rec_error, 1);
    chk("empty_state", bus.dbg_state, ST_IDLE);
    step();

    // final report
    chk("pending_records", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/z80fi_insn_recorder.md
Name: z80fi_insn_recorder

Overview:
- Core-side producer of the z80fi retirement record that the per-instruction spec modules check.
- Watches the core's instruction boundaries, opcode/operand byte fetches and register writebacks.
- Assembles one record per instruction: little-endian instruction bytes, length, starting PC and register write.
- Issues that record as a single-cycle z80fi_valid pulse.

Parameters:
- MAX_LEN, 4, maximum instruction length in bytes; sets z80fi_insn width to 8*MAX_LEN.

Ports:
- clk  input  1  core clock
- reset_n  input  1  asynchronous active-low reset
- insn_start  input  1  pulse: first cycle of a new instruction (M1 of first opcode byte)
- insn_pc  input  16  PC of the instruction starting; sampled with insn_start
- fetch_valid  input  1  an instruction byte (opcode, prefix, displacement or immediate) is read this cycle
- fetch_data  input  8  that byte
- wb_valid  input  1  register pair/register write this cycle
- wb_num  input  4  register number, same encoding as z80fi reg numbers (pairs are {2'b10,dd})
- wb_data  input  16  write data
- retire  input  1  pulse: current instruction completes this cycle
- z80fi_valid  output  1  one-cycle record strobe
- z80fi_insn  output  8*MAX_LEN  instruction bytes; byte 0 at [7:0]
- z80fi_insn_len  output  3  byte count, 1..MAX_LEN
- z80fi_pc_rdata  output  16  PC at instruction start
- z80fi_reg_wr  output  1  instruction wrote a register
- z80fi_reg_wnum  output  4  register written
- z80fi_reg_wdata  output  16  value written
- rec_overflow  output  1  record had more than MAX_LEN bytes; valid with z80fi_valid
- rec_error  output  1  sticky protocol error

Behaviour:
- Reset (reset_n low, asynchronous):
  - All outputs 0, state IDLE.
  - Collection buffers cleared.
  - Reset mid-instruction discards the partial record; no z80fi_valid is issued.
- States: IDLE, COLLECT.
  - IDLE --insn_start--> COLLECT.
  - COLLECT --retire without insn_start--> IDLE.
  - COLLECT --retire with insn_start--> COLLECT (back-to-back instructions).
- On insn_start:
  - Latch insn_pc.
  - Clear byte buffer to 0, count to 0, pending reg write and overflow.
  - A fetch_valid in the same cycle is stored as byte 0 (count becomes 1).
- In COLLECT, each fetch_valid:
  - Writes fetch_data to byte slot [count], then count+1.
  - If count == MAX_LEN, the byte is dropped, count saturates and the overflow flag is set.
- wb_valid in COLLECT latches wb_num/wb_data and sets pending reg_wr. A second write in the same instruction overwrites (last wins).
- fetch_valid or wb_valid arriving in the retire cycle belongs to the retiring instruction.
- Retire in COLLECT:
  - Next cycle: z80fi_valid = 1 for exactly one cycle.
  - Record outputs show the retired instruction's buffer, count, PC, reg write and overflow.
  - Latency: retire at cycle N -> z80fi_valid at N+1.
- Record outputs hold their values until the next z80fi_valid; only z80fi_valid pulses.
- retire and insn_start together:
  - The record is built from the old instruction's state, including that cycle's fetch/wb (see above).
  - The new instruction's state starts from insn_pc and an empty buffer.
  - That cycle's fetch/wb goes to the old instruction, never to both.
- Protocol errors set rec_error (sticky until reset); none of them generate a record:
  - retire in IDLE: ignored.
  - insn_start in COLLECT without retire: old record abandoned, new instruction starts.
  - retire with count == 0: record suppressed.
  - fetch_valid or wb_valid in IDLE: ignored.
- Widths: count is 3 bits; z80fi_insn_len = count; unused byte slots read 0.

Decomposition:
- Shared package (z80fi.vh additions):
  - record field widths
  - MAX_LEN default
  - the reg-number encoding constants (8-bit regs, pairs prefix 2'b10)
  - state encoding localparams IDLE/COLLECT
- Sub-module z80fi_byte_collector:
  - holds the byte buffer, count and overflow
  - inputs: clear, push, data, and in_retire (so the retire-cycle byte is captured before the clear)
- The top level holds the FSM, PC/writeback latches and output registers.

Test Plan:
- LD BC,1234h:
  - Stimulus: insn_start pc=0100h with byte 01h, then bytes 34h, 12h; wb num=4'b1000 data=1234h; retire.
  - Required next cycle: valid=1, insn=00123401h, len=3, pc=0100h, reg_wr=1, wnum=8, wdata=1234h.
- Back-to-back:
  - Stimulus: LD SP,nn (31h,00h,80h) retires in the same cycle as insn_start pc=0103h of NOP (byte 00h); NOP retires 1 cycle later.
  - Required: two consecutive valid pulses; second record has insn=0, len=1, pc=0103h, reg_wr=0.
- Overflow:
  - Stimulus: 5 fetches DDh,CBh,05h,06h,AAh, then retire.
  - Required: len=4, insn=0605CBDDh, rec_overflow=1, rec_error=0.
- Protocol errors:
  - Stimulus: retire in IDLE, then insn_start twice without retire, then retire.
  - Required: rec_error=1; exactly one valid, carrying the second pc.
- Async reset:
  - Stimulus: reset_n low mid-COLLECT (two bytes fetched), release, then retire.
  - Required: all outputs 0 immediately; no valid follows.
- Same-cycle fetch+retire:
  - Stimulus: final immediate byte 56h and wb arrive in the retire cycle.
  - Required: record includes 56h in the top filled slot and reg_wr=1.
